// File: rtl/debounce_pkg.sv
// Shared constants and width helper for the debouncer family.
package debounce_pkg;

    localparam int DEFAULT_DEBOUNCE_COUNT = 16;
    localparam int DEFAULT_SYNC_STAGES    = 2;

    // Bits needed to hold 0..max_val; never below 1 so degenerate counts stay legal.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced channel: synchroniser, stability counter, edge pulses, optional hold detect.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int   DEBOUNCE_COUNT = DEFAULT_DEBOUNCE_COUNT,
    parameter int   SYNC_STAGES    = DEFAULT_SYNC_STAGES,
    parameter logic RST_VAL        = 1'b0,
    parameter int   HOLD_COUNT     = 0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic in_i,
    output logic out_o,
    output logic rise_o,
    output logic fall_o,
    output logic hold_o
);

    localparam int              CW       = cnt_width(DEBOUNCE_COUNT);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_COUNT - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   out_q, out_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in_i};
        cnt_d  = '0;
        out_d  = out_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        // Any cycle where the synchronised input agrees with the output restarts the count.
        if (s != out_q) begin
            if (cnt_q == CNT_LAST) begin
                out_d  = s;
                rise_d = s;
                fall_d = ~s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            cnt_q  <= '0;
            out_q  <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign out_o  = out_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

    if (HOLD_COUNT > 0) begin : g_hold
        localparam int            HW        = cnt_width(HOLD_COUNT);
        localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_COUNT);
        localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_COUNT - 1);

        logic [HW-1:0] hcnt_q, hcnt_d;
        logic          hold_q, hold_d;

        // hcnt saturates at HOLD_MAX so only one pulse fires per press.
        always_comb begin
            hcnt_d = '0;
            hold_d = 1'b0;
            if (out_q) begin
                hcnt_d = (hcnt_q == HOLD_MAX) ? hcnt_q : hcnt_q + 1'b1;
                hold_d = (hcnt_q == HOLD_LAST);
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                hcnt_q <= '0;
                hold_q <= 1'b0;
            end else begin
                hcnt_q <= hcnt_d;
                hold_q <= hold_d;
            end
        end

        assign hold_o = hold_q;
    end else begin : g_no_hold
        assign hold_o = 1'b0;
    end

endmodule

// File: rtl/multi_debouncer.sv
// NUM_CH independent debounce channels with per-channel edge/hold pulses and a global change flag.
module multi_debouncer
    import debounce_pkg::*;
#(
    parameter int   NUM_CH         = 4,
    parameter int   DEBOUNCE_COUNT = DEFAULT_DEBOUNCE_COUNT,
    parameter int   SYNC_STAGES    = DEFAULT_SYNC_STAGES,
    parameter logic RST_VAL        = 1'b0,
    parameter int   HOLD_COUNT     = 0
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] in_sig,
    output logic [NUM_CH-1:0] out_sig,
    output logic [NUM_CH-1:0] rise_pulse,
    output logic [NUM_CH-1:0] fall_pulse,
    output logic [NUM_CH-1:0] hold_pulse,
    output logic              any_change
);

    if (NUM_CH < 1) begin : g_bad_num_ch
        $error("multi_debouncer: NUM_CH must be >= 1");
    end
    if (DEBOUNCE_COUNT < 1) begin : g_bad_debounce
        $error("multi_debouncer: DEBOUNCE_COUNT must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("multi_debouncer: SYNC_STAGES must be >= 2");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_COUNT(DEBOUNCE_COUNT),
            .SYNC_STAGES   (SYNC_STAGES),
            .RST_VAL       (RST_VAL),
            .HOLD_COUNT    (HOLD_COUNT)
        ) u_ch (
            .clk_i (sys_clk),
            .rst_ni(rst),
            .in_i  (in_sig[i]),
            .out_o (out_sig[i]),
            .rise_o(rise_pulse[i]),
            .fall_o(fall_pulse[i]),
            .hold_o(hold_pulse[i])
        );
    end

    assign any_change = |(rise_pulse | fall_pulse);

endmodule
